// File: rtl/uart_rx_mmio.sv
`default_nettype none
// uart_rx_mmio: 8N1 serial receiver feeding a small byte FIFO that is read as a
// memory-mapped load word, with per-byte interrupt pulse and sticky error flags.
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        uart_read_end,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        int_sig,
  output logic        overrun,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic sync1;
  logic rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    sh, sh_nx;
  logic          push_req;
  logic          ferr_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sh    <= sh_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    sh_nx    = sh;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rxs) state_nx = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt == HALF_M1) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nx = '0;
          sh_nx  = {rxs, sh[7:1]};
          idx_nx = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          if (rxs) push_req = 1'b1;
          else     ferr_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rp, wp, rp_nx;
  logic [PW:0]   count, count_nx;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          push_rej;
  logic [7:0]    head_nx;

  assign pop      = uart_read_end && rx_valid;
  assign full     = (count == DEPTH);
  assign push_ok  = push_req && (!full || pop);
  assign push_rej = push_req && full && !pop;
  assign rp_nx    = pop ? rp + PW'(1) : rp;

  always_comb begin
    count_nx = count;
    if (push_ok && !pop)      count_nx = count + (PW + 1)'(1);
    else if (!push_ok && pop) count_nx = count - (PW + 1)'(1);
  end

  // Forward the incoming byte when it lands in the slot that becomes the head.
  always_comb begin
    head_nx = mem[rp_nx];
    if (push_ok && (rp_nx == wp)) head_nx = sh;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= sh;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp        <= '0;
      wp        <= '0;
      count     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      int_sig   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rp       <= rp_nx;
      count    <= count_nx;
      if (push_ok) wp <= wp + PW'(1);
      rx_valid <= (count_nx != '0);
      rx_data  <= (count_nx != '0) ? {24'b0, head_nx} : 32'h0;
      int_sig  <= push_ok;
      // A new error in the same cycle as a pop leaves the flag set.
      if (push_rej)  overrun <= 1'b1;
      else if (pop)  overrun <= 1'b0;
      if (ferr_set)  frame_err <= 1'b1;
      else if (pop)  frame_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
`default_nettype none
// Directed bench for uart_rx_mmio: frames, FIFO order/wrap, overrun,
// framing error, glitch rejection, pop/push collision and async reset.
module tb_uart_rx_mmio;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic        uart_read_end = 1'b0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        int_sig;
  logic        overrun;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int int_cnt = 0;
  int int_cyc = 0;
  int frame_start = 0;
  int n0 = 0;

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .uart_read_end(uart_read_end),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .int_sig(int_sig),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (int_sig) begin
      int_cnt <= int_cnt + 1;
      int_cyc <= cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx = 1'b1;
      uart_read_end = 1'b0;
    end
  endtask

  // Drives one 10-bit frame; pop_at selects the cycle index that raises uart_read_end.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == 0) frame_start = cyc;
      rx = bits[i / CPB];
      uart_read_end = (i == pop_at);
    end
  endtask

  task automatic pop();
    @(negedge clk);
    uart_read_end = 1'b1;
    @(negedge clk);
    uart_read_end = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 32'h0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_int_sig", {31'b0, int_sig}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    rst = 1'b1;
    idle(5);

    // Single byte and its latency
    n0 = int_cnt;
    send_frame(8'hA5, 1'b1, -1);
    idle(4);
    check("a5_int_count", int_cnt - n0, 32'd1);
    check("a5_latency_window", {31'b0, (int_cyc - frame_start >= 150) && (int_cyc - frame_start <= 160)}, 32'd1);
    check("a5_rx_data", rx_data, 32'h0000_00A5);
    check("a5_rx_valid", {31'b0, rx_valid}, 32'd1);
    pop();
    check("a5_pop_valid", {31'b0, rx_valid}, 32'd0);
    check("a5_pop_data", rx_data, 32'h0);

    // Four back-to-back frames, pointer wrap
    n0 = int_cnt;
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'h02, 1'b1, -1);
    send_frame(8'h03, 1'b1, -1);
    send_frame(8'h04, 1'b1, -1);
    idle(4);
    check("b2b_int_count", int_cnt - n0, 32'd4);
    check("b2b_head0", rx_data, 32'h01);
    pop();
    check("b2b_head1", rx_data, 32'h02);
    pop();
    check("b2b_head2", rx_data, 32'h03);
    pop();
    check("b2b_head3", rx_data, 32'h04);
    pop();
    check("b2b_empty_valid", {31'b0, rx_valid}, 32'd0);

    // Five frames into a four-deep FIFO
    n0 = int_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h12, 1'b1, -1);
    send_frame(8'h13, 1'b1, -1);
    send_frame(8'h14, 1'b1, -1);
    send_frame(8'h15, 1'b1, -1);
    idle(4);
    check("ovr_int_count", int_cnt - n0, 32'd4);
    check("ovr_flag_set", {31'b0, overrun}, 32'd1);
    check("ovr_head0", rx_data, 32'h11);
    pop();
    check("ovr_flag_cleared", {31'b0, overrun}, 32'd0);
    check("ovr_head1", rx_data, 32'h12);
    pop();
    check("ovr_head2", rx_data, 32'h13);
    pop();
    check("ovr_head3", rx_data, 32'h14);
    pop();
    check("ovr_empty_valid", {31'b0, rx_valid}, 32'd0);
    check("ovr_empty_data", rx_data, 32'h0);

    // Stop bit low
    n0 = int_cnt;
    send_frame(8'h3C, 1'b0, -1);
    idle(40);
    check("ferr_flag", {31'b0, frame_err}, 32'd1);
    check("ferr_no_push", {31'b0, rx_valid}, 32'd0);
    check("ferr_no_int", int_cnt - n0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("ferr_reset_clear", {31'b0, frame_err}, 32'd0);

    // Short low glitch
    n0 = int_cnt;
    idle(5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(60);
    check("glitch_no_int", int_cnt - n0, 32'd0);
    check("glitch_no_valid", {31'b0, rx_valid}, 32'd0);
    check("glitch_no_ferr", {31'b0, frame_err}, 32'd0);
    check("glitch_no_ovr", {31'b0, overrun}, 32'd0);

    // Pop coincides with a push into a full FIFO
    n0 = int_cnt;
    send_frame(8'h21, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    send_frame(8'h23, 1'b1, -1);
    send_frame(8'h24, 1'b1, -1);
    send_frame(8'h25, 1'b1, 154);
    idle(4);
    check("coll_int_count", int_cnt - n0, 32'd5);
    check("coll_overrun", {31'b0, overrun}, 32'd0);
    check("coll_head0", rx_data, 32'h22);
    pop();
    check("coll_head1", rx_data, 32'h23);
    pop();
    check("coll_head2", rx_data, 32'h24);
    pop();
    check("coll_head3", rx_data, 32'h25);
    check("coll_valid_last", {31'b0, rx_valid}, 32'd1);
    pop();
    check("coll_empty_valid", {31'b0, rx_valid}, 32'd0);

    // Asynchronous reset mid-frame
    send_frame(8'h31, 1'b1, -1);
    send_frame(8'h32, 1'b1, -1);
    idle(4);
    check("arst_pre_valid", {31'b0, rx_valid}, 32'd1);
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_rx_data", rx_data, 32'h0);
    check("arst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("arst_int_sig", {31'b0, int_sig}, 32'd0);
    check("arst_overrun", {31'b0, overrun}, 32'd0);
    check("arst_frame_err", {31'b0, frame_err}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(20);
    n0 = int_cnt;
    send_frame(8'h5A, 1'b1, -1);
    idle(4);
    check("arst_next_int", int_cnt - n0, 32'd1);
    check("arst_next_data", rx_data, 32'h5A);
    check("arst_next_valid", {31'b0, rx_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
